cpu_datapath: RTL and testbench
===============================

Name: cpu_datapath

Overview:
Datapath stage directly downstream of the lab CPU controller FSM. It consumes the controller's per-cycle control word (nsel, vsel, write, looada/b/c, looads, asel, bsel) and the current 16-bit instruction. It holds an 8x16 register file, the A/B operand registers, a shifter, an ALU, the C result register and the Z/N/V status flags. It executes MOV imm, MOV shift, ADD, CMP, AND and MVN over the controller's multi-cycle sequence.

Parameters:
- DW, 16, datapath word width
- NREG, 8, number of general registers (index width 3)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- instr  in  16  current instruction register contents
- nsel  in  3  one-hot register select: [2]=Rn (instr[10:8]), [1]=Rd (instr[7:5]), [0]=Rm (instr[2:0])
- vsel  in  2  writeback source: 00=C, 01=sximm8, 10=mdata, 11={8'b0,pc}
- write  in  1  register-file write enable
- looada  in  1  load A from read port
- looadb  in  1  load B from read port
- looadc  in  1  load C from ALU output
- looads  in  1  load status flags from ALU
- asel  in  1  1: ALU Ain = 0; 0: Ain = A
- bsel  in  1  1: ALU Bin = sximm5; 0: Bin = shifted B
- mdata  in  16  memory read data
- pc  in  8  program counter
- datapath_out  out  16  C register
- z_flag, n_flag, v_flag  out  1 each  status register

Behaviour:
- Reset, synchronous: R0-R7, A, B, C, Z, N and V all clear to 0 on the next clk edge with reset=1. Reset overrides every write and load in that cycle. Reset can arrive mid-instruction; the datapath takes no part in recovery.
- Register index: nsel one-hot selects the instr field named above.
- Any non-one-hot nsel (000 or multi-hot):
  - the read port returns R0;
  - write is suppressed.
- Read port is combinational from the register file at the selected index.
- Write: when write=1, the selected register takes the vsel-selected value at the clk edge. The value is visible on the read port the next cycle.
- Same-cycle write and looada/looadb to the same index: A/B capture the pre-write (old) value. There is no bypass.
- sximm8 = sign-extend instr[7:0]; sximm5 = sign-extend instr[4:0].
- Shifter on B, field instr[4:3]:
  - 00 pass
  - 01 LSL by 1, fill 0
  - 10 LSR by 1, fill 0
  - 11 ASR by 1, fill with B[15]
- ALU op instr[12:11]: 00 ADD, 01 SUB (Ain-Bin), 10 AND, 11 NOT Bin. Result is 16-bit, with wrap-around modulo 2^16.
- Flags, registered only when looads=1:
  - Z = (result==0)
  - N = result[15]
  - V for ADD = (a15==b15)&&(r15!=a15)
  - V for SUB = (a15!=b15)&&(r15!=a15)
  - V = 0 for AND and NOT.
- looadc=1 registers the ALU result into C. looadc and looads are independent: CMP asserts only looads, so C is unchanged.
- Latency:
  - read to A/B: 1 edge
  - A/B to C/flags: 1 edge
  - C to register file via vsel=00: 1 edge
  - a full ALU instruction therefore spans the controller's 3 execute states.
- All registers hold their value when their enable is low.

Decomposition:
- Shared package (cpu_defs):
  - ALU op codes (ADD/SUB/AND/NOT)
  - shift codes
  - vsel encodings
  - nsel bit positions
  - instr field bit ranges
  - DW
  The controller imports the same package.
- One sub-module: cpu_regfile, 8x16, one combinational read port, one synchronous write port, synchronous reset. Shifter, ALU and flags stay inline.

Test Plan:
- MOV imm: instr=16'hD105 (Rn=1, imm8=5), vsel=01, nsel=100, write=1 -> R1=0x0005. Repeat with imm8=0xF0 -> R1=0xFFF0 (sign extension).
- ADD: R1=5, R2=7, load A from Rn=1 and B from Rm=2, op=00, shift=00, looadc -> C=0x000C. Write to Rd=3 with vsel=00 -> R3=0x000C. Z=0, N=0.
- CMP overflow: A=0x7FFF, B=0xFFFF, SUB with looads only -> V=1, N=1, Z=0, and C unchanged from its prior value. A=B=0x1234 -> Z=1, V=0.
- Shifts: B=0x8001 with shift 01/10/11, asel=1, MOV -> C = 0x0002 / 0x4000 / 0xC000.
- Same-cycle hazard: write R4=0xAAAA while looada with nsel selecting R4 (old value 0x1111) -> A=0x1111; the next-cycle load gives 0xAAAA.
- Reset mid-operation: R0-R7, C and flags nonzero, assert reset for one edge together with write=1 and looadc=1 -> every register and flag reads 0; R0-R7 are unchanged by the suppressed write.

Source files
------------

// File: rtl/cpu_datapath_pkg.sv
// cpu_defs: encodings and instruction field positions shared by the lab CPU controller and datapath
package cpu_defs;
  localparam int DW = 16;
  localparam int NREG = 8;
  localparam int RW = 3;
  typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_NOT} alu_op_t;
  typedef enum logic [1:0] {SH_PASS, SH_LSL, SH_LSR, SH_ASR} shift_t;
  typedef enum logic [1:0] {VS_C, VS_IMM8, VS_MDATA, VS_PC} vsel_t;
  localparam int NSEL_RN = 2;
  localparam int NSEL_RD = 1;
  localparam int NSEL_RM = 0;
  localparam int OP_HI = 12;
  localparam int OP_LO = 11;
  localparam int RN_HI = 10;
  localparam int RN_LO = 8;
  localparam int RD_HI = 7;
  localparam int RD_LO = 5;
  localparam int SH_HI = 4;
  localparam int SH_LO = 3;
  localparam int RM_HI = 2;
  localparam int RM_LO = 0;
  localparam int IMM8_HI = 7;
  localparam int IMM5_HI = 4;
  typedef struct packed {
    logic ok;
    logic [RW-1:0] idx;
  } reg_sel_t;
  // A malformed nsel reads R0 and must never write.
  function automatic reg_sel_t reg_sel(input logic [2:0] nsel, input logic [15:0] instr);
    logic ok;
    ok = $onehot(nsel);
    return '{ok: ok,
             idx: !ok ? RW'(0) : nsel[NSEL_RN] ? instr[RN_HI:RN_LO] :
                  nsel[NSEL_RD] ? instr[RD_HI:RD_LO] : instr[RM_HI:RM_LO]};
  endfunction
endpackage

// File: rtl/cpu_datapath_regfile.sv
// cpu_regfile: general register file, one combinational read port, one synchronous write port
module cpu_regfile #(
  parameter int DW = 16,
  parameter int NREG = 8,
  parameter int AW = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [NREG];
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end
  assign rdata = mem[raddr];
endmodule

// File: rtl/cpu_datapath.sv
// cpu_datapath: register file, operand registers, shifter, ALU, result register and status flags
module cpu_datapath import cpu_defs::*; #(
  parameter int DW = cpu_defs::DW,
  parameter int NREG = cpu_defs::NREG
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [15:0]   instr,
  input  logic [2:0]    nsel,
  input  logic [1:0]    vsel,
  input  logic          write,
  input  logic          looada,
  input  logic          looadb,
  input  logic          looadc,
  input  logic          looads,
  input  logic          asel,
  input  logic          bsel,
  input  logic [DW-1:0] mdata,
  input  logic [7:0]    pc,
  output logic [DW-1:0] datapath_out,
  output logic          z_flag,
  output logic          n_flag,
  output logic          v_flag
);
  reg_sel_t sel;
  logic [DW-1:0] rdata, wdata, a, b, bsh, ain, bin, res, sximm8, sximm5;
  alu_op_t op;
  shift_t sh;
  logic ovf;
  logic unused_opcode;
  assign unused_opcode = ^instr[15:13];
  assign sel = reg_sel(nsel, instr);
  assign sximm8 = {{(DW-8){instr[IMM8_HI]}}, instr[IMM8_HI:0]};
  assign sximm5 = {{(DW-5){instr[IMM5_HI]}}, instr[IMM5_HI:0]};
  assign wdata = vsel == VS_C ? datapath_out : vsel == VS_IMM8 ? sximm8 :
                 vsel == VS_MDATA ? mdata : {{(DW-8){1'b0}}, pc};
  cpu_regfile #(.DW(DW), .NREG(NREG)) u_rf (
    .clk(clk), .reset(reset), .we(write && sel.ok), .waddr(sel.idx),
    .wdata(wdata), .raddr(sel.idx), .rdata(rdata)
  );
  assign sh = shift_t'(instr[SH_HI:SH_LO]);
  assign op = alu_op_t'(instr[OP_HI:OP_LO]);
  assign bsh = sh == SH_LSL ? {b[DW-2:0], 1'b0} : sh == SH_LSR ? {1'b0, b[DW-1:1]} :
               sh == SH_ASR ? {b[DW-1], b[DW-1:1]} : b;
  assign ain = asel ? '0 : a;
  assign bin = bsel ? sximm5 : bsh;
  assign res = op == ALU_ADD ? ain + bin : op == ALU_SUB ? ain - bin :
               op == ALU_AND ? ain & bin : ~bin;
  assign ovf = op == ALU_ADD ? (ain[DW-1] == bin[DW-1]) && (res[DW-1] != ain[DW-1]) :
               op == ALU_SUB ? (ain[DW-1] != bin[DW-1]) && (res[DW-1] != ain[DW-1]) : 1'b0;
  always_ff @(posedge clk) begin
    if (reset) begin
      a <= '0;
      b <= '0;
      datapath_out <= '0;
      {z_flag, n_flag, v_flag} <= '0;
    end else begin
      if (looada) a <= rdata;
      if (looadb) b <= rdata;
      if (looadc) datapath_out <= res;
      if (looads) {z_flag, n_flag, v_flag} <= {res == '0, res[DW-1], ovf};
    end
  end
endmodule

// File: tb/tb_cpu_datapath.sv
// tb_cpu_datapath: directed plan plus random control words against an arithmetic reference model
module tb_cpu_datapath;
  logic clk = 0, reset = 0, write = 0, looada = 0, looadb = 0, looadc = 0, looads = 0, asel = 0, bsel = 0;
  logic [15:0] instr = 0, mdata = 0, datapath_out;
  logic [2:0] nsel = 0;
  logic [1:0] vsel = 0;
  logic [7:0] pc = 0;
  logic z_flag, n_flag, v_flag;
  logic [15:0] rf [8];
  logic [15:0] ma, mb, mc;
  logic mz, mn, mv;
  int checks = 0, fails = 0;
  cpu_datapath dut (
    .clk(clk), .reset(reset), .instr(instr), .nsel(nsel), .vsel(vsel), .write(write),
    .looada(looada), .looadb(looadb), .looadc(looadc), .looads(looads), .asel(asel),
    .bsel(bsel), .mdata(mdata), .pc(pc), .datapath_out(datapath_out),
    .z_flag(z_flag), .n_flag(n_flag), .v_flag(v_flag)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [15:0] ai(input int op, input int rn, input int rd, input int s, input int rm);
    return {3'b101, 2'(op), 3'(rn), 3'(rd), 2'(s), 3'(rm)};
  endfunction
  function automatic logic [15:0] mi(input int rn, input int imm);
    return {5'b11010, 3'(rn), 8'(imm)};
  endfunction
  task automatic cyc(input logic rs, input logic [15:0] i, input logic [2:0] ns, input logic [1:0] vs,
                     input logic w, la, lb, lc, ls, as, bs, input logic [15:0] md);
    int idx, sa, sb, sr, sv;
    bit ok, ov;
    logic [15:0] rv, wv, shv, ain, bin, r;
    reset = rs; instr = i; nsel = ns; vsel = vs; write = w; looada = la; looadb = lb;
    looadc = lc; looads = ls; asel = as; bsel = bs; mdata = md;
    ok = (ns == 3'b100) || (ns == 3'b010) || (ns == 3'b001);
    idx = ns == 3'b100 ? int'(i[10:8]) : ns == 3'b010 ? int'(i[7:5]) : ns == 3'b001 ? int'(i[2:0]) : 0;
    rv = rf[idx];
    sa = $signed(i[7:0]);
    wv = vs == 0 ? mc : vs == 1 ? 16'(sa) : vs == 2 ? md : {8'h00, pc};
    sv = $signed(mb);
    case (i[4:3])
      2'd0: shv = mb;
      2'd1: shv = 16'(mb * 2);
      2'd2: shv = mb / 2;
      default: shv = 16'((sv - (sv & 1)) / 2);
    endcase
    ain = as ? 16'h0 : ma;
    sb = $signed(i[4:0]);
    bin = bs ? 16'(sb) : shv;
    sa = $signed(ain);
    sb = $signed(bin);
    ov = 0;
    case (i[12:11])
      2'd0: begin sr = sa + sb; r = 16'(sr); ov = sr > 32767 || sr < -32768; end
      2'd1: begin sr = sa - sb; r = 16'(sr); ov = sr > 32767 || sr < -32768; end
      2'd2: r = ain & bin;
      default: r = ~bin;
    endcase
    @(posedge clk);
    if (rs) begin
      for (int k = 0; k < 8; k++) rf[k] = 0;
      ma = 0; mb = 0; mc = 0; mz = 0; mn = 0; mv = 0;
    end else begin
      if (w && ok) rf[idx] = wv;
      if (la) ma = rv;
      if (lb) mb = rv;
      if (lc) mc = r;
      if (ls) begin mz = r == 0; mn = r[15]; mv = ov; end
    end
    #1;
    chk("c", datapath_out, mc);
    chk("z", 16'(z_flag), 16'(mz));
    chk("n", 16'(n_flag), 16'(mn));
    chk("v", 16'(v_flag), 16'(mv));
  endtask
  task automatic wrm(input int rn, input logic [15:0] v);
    cyc(0, mi(rn, 0), 3'b100, 2'b10, 1, 0, 0, 0, 0, 0, 0, v);
  endtask
  task automatic rdc(input int idx, input logic [15:0] exp, input string tag);
    cyc(0, ai(0, idx, 0, 0, 0), 3'b100, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    cyc(0, ai(0, 0, 0, 0, 0), 3'b000, 0, 0, 0, 0, 1, 0, 0, 1, 0);
    chk(tag, datapath_out, exp);
  endtask
  logic [15:0] shx [3] = '{16'h0002, 16'h4000, 16'hC000};
  initial begin
    for (int k = 0; k < 8; k++) rf[k] = 0;
    ma = 0; mb = 0; mc = 0; mz = 0; mn = 0; mv = 0;
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_c", datapath_out, 16'h0);
    chk("rst_flags", 16'({z_flag, n_flag, v_flag}), 16'h0);
    cyc(0, 16'hD105, 3'b100, 2'b01, 1, 0, 0, 0, 0, 0, 0, 0);
    rdc(1, 16'h0005, "movimm_pos");
    cyc(0, mi(1, 8'hF0), 3'b100, 2'b01, 1, 0, 0, 0, 0, 0, 0, 0);
    rdc(1, 16'hFFF0, "movimm_sext");
    cyc(0, mi(1, 5), 3'b100, 2'b01, 1, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, mi(2, 7), 3'b100, 2'b01, 1, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, ai(0, 1, 0, 0, 0), 3'b100, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    cyc(0, ai(0, 0, 0, 0, 2), 3'b001, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    cyc(0, ai(0, 0, 0, 0, 0), 3'b000, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    chk("add_c", datapath_out, 16'h000C);
    chk("add_zn", 16'({z_flag, n_flag}), 16'h0);
    cyc(0, ai(0, 0, 3, 0, 0), 3'b010, 2'b00, 1, 0, 0, 0, 0, 0, 0, 0);
    rdc(3, 16'h000C, "add_wb");
    wrm(6, 16'h7FFF);
    wrm(5, 16'hFFFF);
    rdc(5, 16'hFFFF, "cmp_pre");
    cyc(0, ai(0, 6, 0, 0, 0), 3'b100, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    cyc(0, ai(0, 0, 0, 0, 5), 3'b001, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    cyc(0, ai(1, 0, 0, 0, 0), 3'b000, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    chk("cmp_c_held", datapath_out, 16'hFFFF);
    chk("cmp_znv", 16'({z_flag, n_flag, v_flag}), 16'h3);
    wrm(7, 16'h1234);
    cyc(0, ai(0, 7, 0, 0, 7), 3'b100, 0, 0, 1, 1, 0, 0, 0, 0, 0);
    cyc(0, ai(1, 0, 0, 0, 0), 3'b000, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    chk("cmp_eq_znv", 16'({z_flag, n_flag, v_flag}), 16'h4);
    wrm(2, 16'h8001);
    cyc(0, ai(0, 0, 0, 0, 2), 3'b001, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    for (int s = 1; s <= 3; s++) begin
      cyc(0, ai(0, 0, 0, s, 0), 3'b000, 0, 0, 0, 0, 1, 0, 1, 0, 0);
      chk($sformatf("shift%0d", s), datapath_out, shx[s-1]);
    end
    wrm(4, 16'h1111);
    cyc(0, mi(4, 0), 3'b100, 2'b10, 1, 1, 0, 0, 0, 0, 0, 16'hAAAA);
    cyc(0, ai(0, 0, 0, 0, 0), 3'b000, 0, 0, 0, 0, 1, 0, 0, 1, 0);
    chk("hazard_old", datapath_out, 16'h1111);
    rdc(4, 16'hAAAA, "hazard_new");
    wrm(0, 16'h5A5A);
    cyc(0, mi(0, 0), 3'b000, 2'b10, 1, 0, 0, 0, 0, 0, 0, 16'hBEEF);
    cyc(0, ai(0, 3, 3, 0, 3), 3'b110, 2'b10, 1, 0, 0, 0, 0, 0, 0, 16'hBEEF);
    rdc(0, 16'h5A5A, "nonhot_nowrite");
    rdc(3, 16'h000C, "multihot_nowrite");
    cyc(0, ai(0, 3, 0, 0, 0), 3'b011, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    cyc(0, ai(0, 0, 0, 0, 0), 3'b000, 0, 0, 0, 0, 1, 0, 0, 1, 0);
    chk("multihot_reads_r0", datapath_out, 16'h5A5A);
    for (int k = 0; k < 400; k++) begin
      pc = 8'($urandom);
      cyc($urandom_range(0, 59) == 0, 16'($urandom),
          $urandom_range(0, 3) == 0 ? 3'($urandom) : 3'(1 << $urandom_range(0, 2)),
          2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
          1'($urandom), 1'($urandom), 1'($urandom), 16'($urandom));
    end
    for (int k = 0; k < 8; k++) wrm(k, 16'(16'h1111 * (k + 1)));
    cyc(0, ai(0, 7, 0, 0, 7), 3'b100, 0, 0, 1, 1, 0, 0, 0, 0, 0);
    cyc(0, ai(0, 0, 0, 0, 0), 3'b000, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    chk("pre_rst_v", 16'(v_flag), 16'h1);
    cyc(1, mi(2, 0), 3'b100, 2'b10, 1, 1, 1, 1, 1, 0, 0, 16'hFFFF);
    chk("mid_rst_c", datapath_out, 16'h0);
    chk("mid_rst_flags", 16'({z_flag, n_flag, v_flag}), 16'h0);
    for (int k = 0; k < 8; k++) rdc(k, 16'h0, $sformatf("mid_rst_r%0d", k));
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
